// File: rtl/nmr_bstrm_pkg.sv
// Shared types and command-word field layout for the multi-channel bitstream generator.
// Field offsets are functions of the channel count and the duration/loop widths.
package nmr_bstrm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_END   = 2'd3
    } state_e;

    localparam int LVL_LSB = 0;

    function automatic int dur_lsb(input int nch);
        return nch;
    endfunction

    function automatic int lcnt_lsb(input int nch, input int dur_w);
        return nch + dur_w;
    endfunction

    function automatic int loop_start_bit(input int nch, input int dur_w, input int loop_w);
        return nch + dur_w + loop_w;
    endfunction

    function automatic int loop_end_bit(input int nch, input int dur_w, input int loop_w);
        return nch + dur_w + loop_w + 1;
    endfunction

    function automatic int seq_end_bit(input int nch, input int dur_w, input int loop_w);
        return nch + dur_w + loop_w + 2;
    endfunction

    function automatic int word_used_w(input int nch, input int dur_w, input int loop_w);
        return nch + dur_w + loop_w + 3;
    endfunction

endpackage

// File: rtl/nmr_bstrm_fetch.sv
// SRAM read pipeline: tracks in-flight reads through the fixed read latency and
// holds one prefetched word; the arriving word bypasses the buffer when consumed at once.
module nmr_bstrm_fetch #(
    parameter int W      = 55,
    parameter int RD_LAT = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         flush_i,
    input  logic         rd_issue_i,
    input  logic [W-1:0] rd_dat_i,
    input  logic         consume_i,
    output logic         avail_o,
    output logic [W-1:0] word_o
);

    logic [RD_LAT-1:0] lat_q, lat_d;
    logic              buf_vld_q, buf_vld_d;
    logic [W-1:0]      buf_q;
    logic              arrive;
    logic              store;

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign lat_d = rd_issue_i;
        end else begin : g_latn
            assign lat_d = {lat_q[RD_LAT-2:0], rd_issue_i};
        end
    endgenerate

    assign arrive  = lat_q[RD_LAT-1];
    assign avail_o = buf_vld_q | arrive;
    assign word_o  = buf_vld_q ? buf_q : rd_dat_i;

    // Arriving data is kept unless it is being consumed straight off the bus.
    always_comb begin
        store     = arrive && !flush_i && !(consume_i && !buf_vld_q);
        buf_vld_d = buf_vld_q;
        if (flush_i) begin
            buf_vld_d = 1'b0;
        end else if (store) begin
            buf_vld_d = 1'b1;
        end else if (consume_i) begin
            buf_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lat_q     <= '0;
            buf_vld_q <= 1'b0;
        end else begin
            lat_q     <= flush_i ? '0 : lat_d;
            buf_vld_q <= buf_vld_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (store) begin
            buf_q <= rd_dat_i;
        end
    end

endmodule

// File: rtl/nmr_bstrm_mch_gen.sv
// Multi-channel bitstream generator: steps through SRAM command words, holding each
// word's channel levels for its duration, with one-word prefetch and one loop level.
module nmr_bstrm_mch_gen
    import nmr_bstrm_pkg::*;
#(
    parameter int                NCH               = 4,
    parameter int                DUR_WIDTH         = 32,
    parameter int                LOOP_WIDTH        = 16,
    parameter int                SRAM_ADDR_WIDTH   = 8,
    parameter int                SRAM_DAT_WIDTH    = 128,
    parameter int                SRAM_BYTEEN_WIDTH = 16,
    parameter int                SRAM_RD_LAT       = 2,
    parameter logic [NCH-1:0]    IDLE_LEVEL        = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         START,
    input  logic                         ABORT,
    input  logic [SRAM_ADDR_WIDTH-1:0]   START_ADDR,
    output logic                         BUSY,
    output logic                         DONE,
    output logic                         UNDERRUN,
    output logic [SRAM_ADDR_WIDTH-1:0]   SRAM_ADDR,
    output logic                         SRAM_CS,
    output logic                         SRAM_CLKEN,
    output logic                         SRAM_WR,
    output logic [SRAM_DAT_WIDTH-1:0]    SRAM_WR_DAT,
    output logic [SRAM_BYTEEN_WIDTH-1:0] SRAM_BYTEEN,
    input  logic [SRAM_DAT_WIDTH-1:0]    SRAM_RD_DAT,
    output logic [NCH-1:0]               OUT
);

    localparam int DUR_LSB  = dur_lsb(NCH);
    localparam int LCNT_LSB = lcnt_lsb(NCH, DUR_WIDTH);
    localparam int LS_BIT   = loop_start_bit(NCH, DUR_WIDTH, LOOP_WIDTH);
    localparam int LE_BIT   = loop_end_bit(NCH, DUR_WIDTH, LOOP_WIDTH);
    localparam int SE_BIT   = seq_end_bit(NCH, DUR_WIDTH, LOOP_WIDTH);
    localparam int USED_W   = word_used_w(NCH, DUR_WIDTH, LOOP_WIDTH);

    localparam logic [SRAM_ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [DUR_WIDTH-1:0]       DUR_ONE  = 1;
    localparam logic [LOOP_WIDTH:0]        ITER_ONE = 1;

    generate
        if (USED_W > SRAM_DAT_WIDTH) begin : g_bad_width
            $error("nmr_bstrm_mch_gen: command word fields exceed SRAM_DAT_WIDTH");
        end
        if (SRAM_RD_LAT < 1) begin : g_bad_lat
            $error("nmr_bstrm_mch_gen: SRAM_RD_LAT must be at least 1");
        end
        if (USED_W < SRAM_DAT_WIDTH) begin : g_unused
            logic unused_rd_bits;
            assign unused_rd_bits = ^SRAM_RD_DAT[SRAM_DAT_WIDTH-1:USED_W];
        end
    endgenerate

    state_e                     state_q, state_d;
    logic [NCH-1:0]             out_q;
    logic [DUR_WIDTH-1:0]       cnt_q;
    logic                       cur_end_q;
    logic [LOOP_WIDTH-1:0]      iter_q, iter_nx, iter_base;
    logic [SRAM_ADDR_WIDTH-1:0] loop_addr_q, loop_addr_nx, addr_q, next_addr;
    logic                       cs_q, done_q, underrun_q;

    logic                       avail;
    logic [USED_W-1:0]          word;
    logic [NCH-1:0]             w_lvl;
    logic [DUR_WIDTH-1:0]       w_dur, dur_ld;
    logic [LOOP_WIDTH-1:0]      w_lcnt;
    logic                       w_ls, w_le, w_se;
    logic                       reentry;
    logic [LOOP_WIDTH:0]        iter_inc;

    logic run, expire, accept_start, load, issue, underrun_evt, finish, busy;

    nmr_bstrm_fetch #(
        .W      (USED_W),
        .RD_LAT (SRAM_RD_LAT)
    ) u_fetch (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .flush_i    (ABORT),
        .rd_issue_i (cs_q),
        .rd_dat_i   (SRAM_RD_DAT[USED_W-1:0]),
        .consume_i  (load),
        .avail_o    (avail),
        .word_o     (word)
    );

    assign w_lvl  = word[LVL_LSB +: NCH];
    assign w_dur  = word[DUR_LSB +: DUR_WIDTH];
    assign w_lcnt = word[LCNT_LSB +: LOOP_WIDTH];
    assign w_ls   = word[LS_BIT];
    assign w_le   = word[LE_BIT];
    assign w_se   = word[SE_BIT];
    assign dur_ld = (w_dur == '0) ? DUR_ONE : w_dur;

    // addr_q still holds the incoming word's own address when it is loaded.
    always_comb begin
        reentry      = (iter_q != '0) && (addr_q == loop_addr_q);
        loop_addr_nx = loop_addr_q;
        iter_base    = iter_q;
        if (w_ls && !reentry) begin
            loop_addr_nx = addr_q;
            iter_base    = '0;
        end
        iter_inc  = {1'b0, iter_base} + ITER_ONE;
        next_addr = addr_q + ADDR_ONE;
        iter_nx   = iter_base;
        if (w_le) begin
            if (iter_inc < {1'b0, w_lcnt}) begin
                next_addr = loop_addr_nx;
                iter_nx   = iter_inc[LOOP_WIDTH-1:0];
            end else begin
                iter_nx   = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ABORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (START) state_d = ST_PRIME;
                ST_PRIME: if (avail) state_d = ST_RUN;
                ST_RUN:   if (expire && cur_end_q) state_d = ST_END;
                ST_END:   state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        run          = (state_q == ST_RUN);
        expire       = (cnt_q == DUR_ONE);
        accept_start = !ABORT && (state_q == ST_IDLE) && START;
        finish       = !ABORT && run && expire && cur_end_q;
        load         = !ABORT && avail &&
                       ((state_q == ST_PRIME) || (run && expire && !cur_end_q));
        underrun_evt = !ABORT && run && expire && !cur_end_q && !avail;
        issue        = accept_start || (load && !w_se);
        busy         = (state_q == ST_PRIME) || run;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_q       <= IDLE_LEVEL;
            cnt_q       <= DUR_ONE;
            cur_end_q   <= 1'b0;
            iter_q      <= '0;
            loop_addr_q <= '0;
            addr_q      <= '0;
            cs_q        <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            cs_q <= issue;
            if (issue) begin
                addr_q <= accept_start ? START_ADDR : next_addr;
            end
            if (ABORT || finish) begin
                out_q <= IDLE_LEVEL;
            end else if (load) begin
                out_q <= w_lvl;
            end
            if (load) begin
                cnt_q       <= dur_ld;
                cur_end_q   <= w_se;
                loop_addr_q <= loop_addr_nx;
                iter_q      <= iter_nx;
            end else if (run && !expire) begin
                cnt_q <= cnt_q - DUR_ONE;
            end else if (accept_start) begin
                iter_q <= '0;
            end
            if (ABORT || accept_start) begin
                done_q <= 1'b0;
            end else if (finish) begin
                done_q <= 1'b1;
            end
            if (accept_start) begin
                underrun_q <= 1'b0;
            end else if (underrun_evt) begin
                underrun_q <= 1'b1;
            end
        end
    end

    assign BUSY        = busy;
    assign DONE        = done_q;
    assign UNDERRUN    = underrun_q;
    assign OUT         = out_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_CS     = cs_q;
    assign SRAM_CLKEN  = cs_q;
    assign SRAM_WR     = 1'b0;
    assign SRAM_WR_DAT = '0;
    assign SRAM_BYTEEN = '1;

endmodule
